// File: rtl/lsu_store_queue.sv
// lsu_store_queue
//   Store queue for the LSU. Stores are allocated at dispatch, receive their
//   address (STA) and data (STD) out of order, are committed in order by the
//   ROB, and drain in order to the D$ one at a time (valid/ready request,
//   then a response ack). Uncommitted entries can be rolled back on redirect.
//
//   Optional feature macro: STQ_FWD_EN (store-to-load forwarding). When it is
//   undefined, a load is blocked by any older in-flight store it depends on.
//
//   Ports
//     clk, rstn                 clock, asynchronous active-low reset
//     alloc_valid/ready/ptr     allocation at tail; ptr carries the wrap bit
//     sta_* / std_*             address / data writes by entry index
//     commit_num                stores committed by the ROB this cycle
//     rollback_valid/ptr        new tail on redirect
//     dreq_* / dresp_valid      D$ store request and its ack
//     ld_* / fwd_*              forwarding probe and combinational result
//     count, empty              occupancy
module lsu_store_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned IDX_W    = $clog2(DEPTH),
  parameter int unsigned COMMIT_W = 2,
  localparam int unsigned CN_W    = $clog2(COMMIT_W + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  output logic [IDX_W:0]   alloc_ptr,
  input  logic             sta_valid,
  input  logic [IDX_W-1:0] sta_idx,
  input  logic [63:0]      sta_addr,
  input  logic [1:0]       sta_size,
  input  logic             std_valid,
  input  logic [IDX_W-1:0] std_idx,
  input  logic [63:0]      std_data,
  input  logic [CN_W-1:0]  commit_num,
  input  logic             rollback_valid,
  input  logic [IDX_W:0]   rollback_ptr,
  output logic             dreq_valid,
  input  logic             dreq_ready,
  output logic [63:0]      dreq_addr,
  output logic [63:0]      dreq_data,
  output logic [7:0]       dreq_mask,
  input  logic             dresp_valid,
  input  logic             ld_valid,
  input  logic [63:0]      ld_addr,
  input  logic [1:0]       ld_size,
  input  logic [DEPTH-1:0] ld_dep_mask,
  output logic             fwd_hit,
  output logic             fwd_block,
  output logic [63:0]      fwd_data,
  output logic [IDX_W:0]   count,
  output logic             empty
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t           r_state;
  logic [IDX_W:0]   r_head, r_cmt, r_tail;
  logic [63:0]      r_addr [DEPTH];
  logic [63:0]      r_data [DEPTH];
  logic [1:0]       r_size [DEPTH];
  logic [DEPTH-1:0] r_av, r_dv, r_cm;
  logic             r_dreq_valid;
  logic [63:0]      r_dreq_addr, r_dreq_data;
  logic [7:0]       r_dreq_mask;

  logic [IDX_W:0]   w_count, w_uncmt, w_cn, w_ncmt;
  logic [IDX_W-1:0] w_head_idx, w_tail_idx;
  logic             w_full, w_alloc, w_sta_ok, w_std_ok, w_eligible;
  logic [DEPTH-1:0] w_cmt_set;

  function automatic logic [7:0] lane_mask(input logic [2:0] off, input logic [1:0] sz);
    logic [7:0] m;
    case (sz)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

  // Physical index lies in [head, tail) when its distance from head is below occupancy.
  function automatic logic in_range(input logic [IDX_W-1:0] idx, input logic [IDX_W-1:0] hd,
                                    input logic [IDX_W:0] cnt);
    logic [IDX_W-1:0] off;
    off = idx - hd;
    return ({1'b0, off} < cnt);
  endfunction

  assign w_count    = r_tail - r_head;
  assign w_uncmt    = r_tail - r_cmt;
  assign w_head_idx = r_head[IDX_W-1:0];
  assign w_tail_idx = r_tail[IDX_W-1:0];
  assign w_full     = (w_count == (IDX_W+1)'(DEPTH));
  assign w_alloc    = alloc_valid & ~w_full;
  assign w_sta_ok   = in_range(sta_idx, w_head_idx, w_count);
  assign w_std_ok   = in_range(std_idx, w_head_idx, w_count);
  assign w_cn       = (IDX_W+1)'(commit_num);
  assign w_ncmt     = (w_cn > w_uncmt) ? w_uncmt : w_cn;
  assign w_eligible = (w_count != '0) & r_cm[w_head_idx] & r_av[w_head_idx] & r_dv[w_head_idx];

  always_comb begin
    w_cmt_set = '0;
    for (int unsigned k = 0; k < COMMIT_W; k++)
      if ((IDX_W+1)'(k) < w_ncmt) w_cmt_set[r_cmt[IDX_W-1:0] + IDX_W'(k)] = 1'b1;
  end

  // Commit/tail pointers and entry flags. Alloc clears are written last so
  // they take precedence; rollback suppresses the alloc entirely.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cmt  <= '0;
      r_tail <= '0;
      r_av   <= '0;
      r_dv   <= '0;
      r_cm   <= '0;
    end else begin
      r_cmt <= r_cmt + w_ncmt;
      r_cm  <= r_cm | w_cmt_set;
      if (sta_valid && w_sta_ok) r_av[sta_idx] <= 1'b1;
      if (std_valid && w_std_ok) r_dv[std_idx] <= 1'b1;
      if (rollback_valid) begin
        r_tail <= rollback_ptr;
      end else if (w_alloc) begin
        r_tail             <= r_tail + (IDX_W+1)'(1);
        r_av[w_tail_idx]   <= 1'b0;
        r_dv[w_tail_idx]   <= 1'b0;
        r_cm[w_tail_idx]   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sta_valid && w_sta_ok) begin
      r_addr[sta_idx] <= sta_addr;
      r_size[sta_idx] <= sta_size;
    end
    if (std_valid && w_std_ok) r_data[std_idx] <= std_data;
  end

  // Drain FSM; request fields are captured on entry to REQ so they hold steady.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_head       <= '0;
      r_dreq_valid <= 1'b0;
      r_dreq_addr  <= '0;
      r_dreq_data  <= '0;
      r_dreq_mask  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_eligible) begin
          r_state      <= S_REQ;
          r_dreq_valid <= 1'b1;
          r_dreq_addr  <= r_addr[w_head_idx];
          r_dreq_data  <= r_data[w_head_idx] << {r_addr[w_head_idx][2:0], 3'b000};
          r_dreq_mask  <= lane_mask(r_addr[w_head_idx][2:0], r_size[w_head_idx]);
        end
        S_REQ: if (dreq_ready) begin
          r_state      <= S_WAIT;
          r_dreq_valid <= 1'b0;
        end
        S_WAIT: if (dresp_valid) begin
          r_state <= S_IDLE;
          r_head  <= r_head + (IDX_W+1)'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef STQ_FWD_EN
  logic             w_found, w_unk;
  logic [IDX_W-1:0] w_fy;
  logic [7:0]       w_ldm, w_stm;

  // Walk oldest to youngest so the last overlapping entry is the youngest.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_block = 1'b0;
    fwd_data  = '0;
    w_found   = 1'b0;
    w_unk     = 1'b0;
    w_fy      = '0;
    w_ldm     = lane_mask(ld_addr[2:0], ld_size);
    w_stm     = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (ld_valid && ((IDX_W+1)'(k) < w_count) && ld_dep_mask[w_head_idx + IDX_W'(k)]) begin
        if (!r_av[w_head_idx + IDX_W'(k)]) begin
          w_unk = 1'b1;
        end else if ((r_addr[w_head_idx + IDX_W'(k)][63:3] == ld_addr[63:3]) &&
                     ((lane_mask(r_addr[w_head_idx + IDX_W'(k)][2:0],
                                 r_size[w_head_idx + IDX_W'(k)]) & w_ldm) != 8'h00)) begin
          w_found = 1'b1;
          w_fy    = w_head_idx + IDX_W'(k);
        end
      end
    end
    if (w_found) begin
      w_stm     = lane_mask(r_addr[w_fy][2:0], r_size[w_fy]);
      fwd_block = w_unk | ((w_ldm & ~w_stm) != 8'h00) | ~r_dv[w_fy];
      if (!fwd_block) begin
        fwd_hit  = 1'b1;
        fwd_data = (r_data[w_fy] << {r_addr[w_fy][2:0], 3'b000}) >> {ld_addr[2:0], 3'b000};
        case (ld_size)
          2'd0:    fwd_data = fwd_data & 64'h0000_0000_0000_00FF;
          2'd1:    fwd_data = fwd_data & 64'h0000_0000_0000_FFFF;
          2'd2:    fwd_data = fwd_data & 64'h0000_0000_FFFF_FFFF;
          default: ;
        endcase
      end
    end else begin
      fwd_block = w_unk;
    end
  end
`else
  logic w_unused_ld;
  assign w_unused_ld = ^{ld_addr, ld_size};

  always_comb begin
    fwd_hit   = 1'b0;
    fwd_data  = '0;
    fwd_block = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++)
      if (ld_valid && ((IDX_W+1)'(k) < w_count) && ld_dep_mask[w_head_idx + IDX_W'(k)])
        fwd_block = 1'b1;
  end
`endif

  assign alloc_ready = ~w_full;
  assign alloc_ptr   = r_tail;
  assign dreq_valid  = r_dreq_valid;
  assign dreq_addr   = r_dreq_addr;
  assign dreq_data   = r_dreq_data;
  assign dreq_mask   = r_dreq_mask;
  assign count       = w_count;
  assign empty       = (w_count == '0);

endmodule

// File: tb/tb_lsu_store_queue.sv
// tb_lsu_store_queue
//   Directed bench for lsu_store_queue (DEPTH=8, COMMIT_W=2). Inputs change
//   1 time unit after the rising edge; outputs are checked at that point.
//   Forwarding vectors follow STQ_FWD_EN the same way the design does.
module tb_lsu_store_queue;

  logic        clk = 1'b0;
  logic        rstn;
  logic        alloc_valid, alloc_ready;
  logic [3:0]  alloc_ptr;
  logic        sta_valid;
  logic [2:0]  sta_idx;
  logic [63:0] sta_addr;
  logic [1:0]  sta_size;
  logic        std_valid;
  logic [2:0]  std_idx;
  logic [63:0] std_data;
  logic [1:0]  commit_num;
  logic        rollback_valid;
  logic [3:0]  rollback_ptr;
  logic        dreq_valid, dreq_ready;
  logic [63:0] dreq_addr, dreq_data;
  logic [7:0]  dreq_mask;
  logic        dresp_valid;
  logic        ld_valid;
  logic [63:0] ld_addr;
  logic [1:0]  ld_size;
  logic [7:0]  ld_dep_mask;
  logic        fwd_hit, fwd_block;
  logic [63:0] fwd_data;
  logic [3:0]  count;
  logic        empty;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_store_queue #(.DEPTH(8), .COMMIT_W(2)) dut (
    .clk(clk), .rstn(rstn),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_ptr(alloc_ptr),
    .sta_valid(sta_valid), .sta_idx(sta_idx), .sta_addr(sta_addr), .sta_size(sta_size),
    .std_valid(std_valid), .std_idx(std_idx), .std_data(std_data),
    .commit_num(commit_num),
    .rollback_valid(rollback_valid), .rollback_ptr(rollback_ptr),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_addr(dreq_addr),
    .dreq_data(dreq_data), .dreq_mask(dreq_mask), .dresp_valid(dresp_valid),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_size(ld_size), .ld_dep_mask(ld_dep_mask),
    .fwd_hit(fwd_hit), .fwd_block(fwd_block), .fwd_data(fwd_data),
    .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    alloc_valid = 0; sta_valid = 0; sta_idx = 0; sta_addr = 0; sta_size = 0;
    std_valid = 0; std_idx = 0; std_data = 0; commit_num = 0;
    rollback_valid = 0; rollback_ptr = 0; dreq_ready = 0; dresp_valid = 0;
    ld_valid = 0; ld_addr = 0; ld_size = 0; ld_dep_mask = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rstn = 0;
    tick();
    tick();
    rstn = 1;
  endtask

  task automatic alloc_n(input int n);
    alloc_valid = 1;
    repeat (n) tick();
    alloc_valid = 0;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [63:0] a, input logic [1:0] sz,
                    input logic [63:0] d, input bit do_a, input bit do_d);
    sta_valid = do_a; sta_idx = idx; sta_addr = a; sta_size = sz;
    std_valid = do_d; std_idx = idx; std_data = d;
    tick();
    sta_valid = 0; std_valid = 0;
  endtask

  task automatic commit(input logic [1:0] n);
    commit_num = n;
    tick();
    commit_num = 0;
  endtask

  // Wait (bounded) for a request, check it, accept it, then ack it.
  task automatic drain_one(input string tag, input logic [63:0] a, input logic [63:0] d,
                           input logic [7:0] m);
    for (int c = 0; c < 20 && dreq_valid !== 1'b1; c++) tick();
    check({tag, "_valid"}, dreq_valid, 1);
    check({tag, "_addr"}, dreq_addr, a);
    check({tag, "_data"}, dreq_data, d);
    check({tag, "_mask"}, dreq_mask, m);
    dreq_ready = 1;
    tick();
    dreq_ready = 0;
    check({tag, "_drop"}, dreq_valid, 0);
    dresp_valid = 1;
    tick();
    dresp_valid = 0;
  endtask

  initial begin
    int cyc;

    // ---- reset values (probe active so the forwarding outputs are exercised)
    clear_inputs();
    rstn = 0;
    ld_valid = 1; ld_dep_mask = 8'hFF;
    tick();
    check("rst_alloc_ready", alloc_ready, 1);
    check("rst_alloc_ptr", alloc_ptr, 0);
    check("rst_dreq_valid", dreq_valid, 0);
    check("rst_fwd_hit", fwd_hit, 0);
    check("rst_fwd_block", fwd_block, 0);
    check("rst_fwd_data", fwd_data, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    apply_reset();

    // ---- fill: alloc_ptr 0..7, full after 8, 9th ignored
    alloc_valid = 1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("fill_ptr%0d", i), alloc_ptr, i);
      check($sformatf("fill_rdy%0d", i), alloc_ready, 1);
      tick();
    end
    check("full_ready", alloc_ready, 0);
    check("full_count", count, 8);
    tick();
    alloc_valid = 0;
    check("ovf_count", count, 8);
    check("ovf_ptr", alloc_ptr, 4'b1000);
    apply_reset();

    // ---- single byte store with lane shift, latency and ignored early dresp
    alloc_n(1);
    wr(3'd0, 64'h1003, 2'd0, 64'hAB, 1, 1);
    commit(2'd1);
    check("lat_cycle0", dreq_valid, 0);
    tick();
    check("lat_cycle1", dreq_valid, 1);
    dresp_valid = 1;
    tick();
    dresp_valid = 0;
    check("req_resp_ign_v", dreq_valid, 1);
    check("req_resp_ign_cnt", count, 1);
    drain_one("byte", 64'h1003, 64'hAB00_0000, 8'h08);
    check("byte_empty", empty, 1);
    apply_reset();

    // ---- alloc 5, commit 2, rollback to 3; only 0..1 drain
    alloc_n(5);
    for (int i = 0; i < 5; i++) wr(3'(i), 64'h100 + 64'(8 * i), 2'd3, 64'h1000 + 64'(i), 1, 1);
    commit(2'd2);
    rollback_valid = 1; rollback_ptr = 4'd3;
    tick();
    rollback_valid = 0;
    check("rb_count", count, 3);
    check("rb_ptr", alloc_ptr, 3);
    drain_one("rb_d0", 64'h100, 64'h1000, 8'hFF);
    drain_one("rb_d1", 64'h108, 64'h1001, 8'hFF);
    repeat (5) tick();
    check("rb_hold_v", dreq_valid, 0);
    check("rb_hold_cnt", count, 1);
    // reset while a request is outstanding
    commit(2'd1);
    for (int c = 0; c < 5 && dreq_valid !== 1'b1; c++) tick();
    check("midrst_pre", dreq_valid, 1);
    rstn = 0;
    #1;
    check("midrst_v", dreq_valid, 0);
    check("midrst_empty", empty, 1);
    apply_reset();

    // ---- wrap: fill, drain 8 in order, refill and time a back-to-back drain
    alloc_n(8);
    for (int i = 0; i < 8; i++) wr(3'(i), 64'h200 + 64'(8 * i), 2'd3, 64'hD0 + 64'(i), 1, 1);
    repeat (4) commit(2'd2);
    check("wrapA_ready", alloc_ready, 0);
    for (int i = 0; i < 8; i++) begin
      drain_one($sformatf("wrapA%0d", i), 64'h200 + 64'(8 * i), 64'hD0 + 64'(i), 8'hFF);
      if (i == 0) check("freed_ready", alloc_ready, 1);
    end
    check("wrapA_ptr", alloc_ptr, 4'b1000);
    check("wrapA_empty", empty, 1);
    alloc_n(8);
    check("wrapB_ptr", alloc_ptr, 4'b0000);
    check("wrapB_count", count, 8);
    check("wrapB_ready", alloc_ready, 0);
    for (int i = 1; i < 8; i++) wr(3'(i), 64'h400 + 64'(8 * i), 2'd3, 64'hE0 + 64'(i), 1, 1);
    wr(3'd0, 64'h400, 2'd3, 64'h0, 1, 0);
    repeat (4) commit(2'd2);
    dreq_ready = 1; dresp_valid = 1;
    wr(3'd0, 64'h0, 2'd0, 64'hE0, 0, 1);
    cyc = 0;
    while (empty !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("wrapB_cycles", 64'(cyc), 24);
    check("wrapB_empty", empty, 1);
    apply_reset();

    // ---- commit 2 + rollback(cmt+2) + ignored alloc in one cycle; commit clamp
    alloc_n(4);
    for (int i = 0; i < 4; i++) wr(3'(i), 64'h300 + 64'(8 * i), 2'd3, 64'h30 + 64'(i), 1, 1);
    commit_num = 2; rollback_valid = 1; rollback_ptr = 4'd2; alloc_valid = 1;
    tick();
    commit_num = 0; rollback_valid = 0; alloc_valid = 0;
    check("crb_count", count, 2);
    check("crb_ptr", alloc_ptr, 2);
    alloc_n(1);
    wr(3'd2, 64'h340, 2'd3, 64'h77, 1, 1);
    commit(2'd2);
    alloc_n(1);
    wr(3'd3, 64'h348, 2'd3, 64'h88, 1, 1);
    commit(2'd1);
    drain_one("crb_d0", 64'h300, 64'h30, 8'hFF);
    drain_one("crb_d1", 64'h308, 64'h31, 8'hFF);
    drain_one("crb_d2", 64'h340, 64'h77, 8'hFF);
    drain_one("crb_d3", 64'h348, 64'h88, 8'hFF);
    check("crb_empty", empty, 1);
    apply_reset();

    // ---- forwarding probe
    alloc_n(1);
    ld_valid = 1; ld_addr = 64'h2004; ld_size = 2'd2; ld_dep_mask = 8'h01;
`ifdef STQ_FWD_EN
    #1;
    check("fwd_noaddr_block", fwd_block, 1);
    check("fwd_noaddr_hit", fwd_hit, 0);
    wr(3'd0, 64'h2000, 2'd3, 64'h1122_3344_5566_7788, 1, 1);
    check("fwd_hit", fwd_hit, 1);
    check("fwd_block", fwd_block, 0);
    check("fwd_data", fwd_data, 64'h1122_3344);
    ld_addr = 64'h3000;
    #1;
    check("fwd_miss_hit", fwd_hit, 0);
    check("fwd_miss_block", fwd_block, 0);
    ld_addr = 64'h2004;
    alloc_n(1);
    ld_dep_mask = 8'h03;
    #1;
    check("fwd_unk_block", fwd_block, 1);
    check("fwd_unk_hit", fwd_hit, 0);
`else
    #1;
    check("nofwd_block", fwd_block, 1);
    check("nofwd_hit", fwd_hit, 0);
    check("nofwd_data", fwd_data, 0);
    ld_dep_mask = 8'h02;
    #1;
    check("nofwd_oor_block", fwd_block, 0);
    ld_valid = 0; ld_dep_mask = 8'h01;
    #1;
    check("nofwd_idle_block", fwd_block, 0);
`endif
    clear_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
